// File: rtl/pulse_seq_gen.sv
// Cycle-exact programmable pulse-train generator: optional delay, then N pulses of
// W active cycles every P cycles (N=0 runs until stop). All outputs are registered.
module pulse_seq_gen #(
  parameter int   CW = 16,
  parameter logic B0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] cfg_delay,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_count,
  output logic          out,
  output logic          outb,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [CW-1:0] pcnt_q, pcnt_n;
  logic [CW-1:0] delay_q, width_q, period_q, count_q;
  logic [CW-1:0] low_len;
  logic          latch;
  logic          done_n, err_n;
  logic          cfg_bad;
  logic          last_pulse;

  assign cfg_bad    = (cfg_width == '0) || (cfg_period <= cfg_width);
  assign low_len    = period_q - width_q;
  assign last_pulse = (count_q != '0) && ((pcnt_q + ONE) == count_q);

  // cnt counts cycles spent in the current state; each timed state exits
  // on the edge that ends its last cycle.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pcnt_n  = pcnt_q;
    latch   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n  = '0;
        pcnt_n = '0;
        if (start && !stop) begin
          if (cfg_bad) begin
            // a held illegal start must not produce back-to-back error strobes
            err_n = !cfg_err;
          end else begin
            latch   = 1'b1;
            state_n = (cfg_delay != '0) ? DELAY : HIGH;
          end
        end
      end
      DELAY: begin
        if (cnt_q == delay_q - ONE) begin
          cnt_n   = '0;
          state_n = HIGH;
        end else begin
          cnt_n = cnt_q + ONE;
        end
      end
      HIGH: begin
        if (cnt_q == width_q - ONE) begin
          cnt_n   = '0;
          state_n = LOW;
        end else begin
          cnt_n = cnt_q + ONE;
        end
      end
      LOW: begin
        if (cnt_q == low_len - ONE) begin
          cnt_n  = '0;
          pcnt_n = pcnt_q + ONE;
          if (last_pulse) begin
            state_n = IDLE;
            pcnt_n  = '0;
            done_n  = 1'b1;
          end else begin
            state_n = HIGH;
          end
        end else begin
          cnt_n = cnt_q + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pcnt_n  = '0;
      end
    endcase
    if (stop && (state_q != IDLE)) begin
      state_n = IDLE;
      cnt_n   = '0;
      pcnt_n  = '0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      delay_q  <= '0;
      width_q  <= '0;
      period_q <= '0;
      count_q  <= '0;
      out      <= B0;
      outb     <= ~B0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pcnt_q  <= pcnt_n;
      if (latch) begin
        delay_q  <= cfg_delay;
        width_q  <= cfg_width;
        period_q <= cfg_period;
        count_q  <= cfg_count;
      end
      // outputs follow the next state so they line up with the state they describe
      out     <= (state_n == HIGH) ? ~B0 : B0;
      outb    <= (state_n == HIGH) ? B0 : ~B0;
      busy    <= (state_n != IDLE);
      done    <= done_n;
      cfg_err <= err_n;
    end
  end

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Self-checking bench for pulse_seq_gen: directed scenarios plus randomized bursts
// checked every cycle against a formula-based model of the pulse timing.
module tb_pulse_seq_gen;
  localparam int   CW = 8;
  localparam logic B0 = 1'b1;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [CW-1:0] cfg_delay, cfg_width, cfg_period, cfg_count;
  logic          out, outb, busy, done, cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_seq_gen #(.CW(CW), .B0(B0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .cfg_period(cfg_period), .cfg_count(cfg_count),
    .out(out), .outb(outb), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  wire [4:0] obs = {out, outb, busy, done, cfg_err};

  // Expected {out,outb,busy,done,cfg_err} in cycle t after the accepting edge.
  function automatic logic [4:0] model(int t, int d, int w, int p, int n);
    int  end_t;
    logic act, bsy, dn;
    end_t = d + n * p;
    act = 1'b0;
    if (t >= d && (n == 0 || t < end_t)) act = ((t - d) % p) < w;
    bsy = (n == 0) ? 1'b1 : (t < end_t);
    dn  = (n != 0) && (t == end_t);
    return {act ? ~B0 : B0, act ? B0 : ~B0, bsy, dn, 1'b0};
  endfunction

  function automatic logic [4:0] idle_vec();
    return {B0, ~B0, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(int d, int w, int p, int n);
    cfg_delay  = CW'(d);
    cfg_width  = CW'(w);
    cfg_period = CW'(p);
    cfg_count  = CW'(n);
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    set_cfg(0, 1, 2, 0);
    rst = 1'b1; start = 1'b1;
    step(); step();
    checks++;
    if (obs !== idle_vec()) begin
      errors++; $display("FAIL reset_hold got=%b exp=%b", obs, idle_vec());
    end
    rst = 1'b0; start = 1'b0;
    step();
    checks++;
    if (obs !== idle_vec()) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", obs, idle_vec());
    end
  endtask

  task automatic test_basic();
    set_cfg(2, 3, 8, 2);
    launch();
    for (int t = 0; t <= 20; t++) begin
      checks++;
      if (obs !== model(t, 2, 3, 8, 2)) begin
        errors++; $display("FAIL basic t=%0d got=%b exp=%b", t, obs, model(t, 2, 3, 8, 2));
      end
      step();
    end
  endtask

  task automatic test_min_config();
    int npulse = 0;
    set_cfg(0, 1, 2, 4);
    launch();
    for (int t = 0; t <= 10; t++) begin
      checks++;
      if (obs !== model(t, 0, 1, 2, 4)) begin
        errors++; $display("FAIL min_cfg t=%0d got=%b exp=%b", t, obs, model(t, 0, 1, 2, 4));
      end
      if (out !== B0) npulse++;
      step();
    end
    checks++;
    if (npulse != 4) begin
      errors++; $display("FAIL min_cfg_pulses got=%0d exp=4", npulse);
    end
  endtask

  task automatic test_illegal();
    int cw[3] = '{0, 5, 6};
    int cp[3] = '{5, 5, 3};
    for (int i = 0; i < 3; i++) begin
      set_cfg(1, cw[i], cp[i], 1);
      launch();
      checks++;
      if (obs !== {B0, ~B0, 3'b001}) begin
        errors++; $display("FAIL illegal_err[%0d] got=%b exp=%b", i, obs, {B0, ~B0, 3'b001});
      end
      step();
      checks++;
      if (obs !== idle_vec()) begin
        errors++; $display("FAIL illegal_after[%0d] got=%b exp=%b", i, obs, idle_vec());
      end
    end
  endtask

  task automatic test_abort();
    set_cfg(1, 4, 10, 0);
    launch();
    for (int t = 0; t <= 2; t++) begin
      checks++;
      if (obs !== model(t, 1, 4, 10, 0)) begin
        errors++; $display("FAIL abort_pre t=%0d got=%b exp=%b", t, obs, model(t, 1, 4, 10, 0));
      end
      if (t == 2) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (obs !== idle_vec()) begin
        errors++; $display("FAIL abort_idle t=%0d got=%b exp=%b", t, obs, idle_vec());
      end
      step();
    end
    launch();
    set_cfg(7, 1, 2, 3);   // must not disturb the running burst
    for (int t = 0; t <= 24; t++) begin
      checks++;
      if (obs !== model(t, 1, 4, 10, 0)) begin
        errors++; $display("FAIL abort_restart t=%0d got=%b exp=%b", t, obs, model(t, 1, 4, 10, 0));
      end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (obs !== idle_vec()) begin
      errors++; $display("FAIL abort_final got=%b exp=%b", obs, idle_vec());
    end
  endtask

  task automatic test_priority();
    set_cfg(0, 2, 4, 1);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int t = 0; t < 2; t++) begin
      checks++;
      if (obs !== idle_vec()) begin
        errors++; $display("FAIL start_stop t=%0d got=%b exp=%b", t, obs, idle_vec());
      end
      step();
    end
    set_cfg(0, 3, 5, 0);
    launch();
    checks++;
    if (obs !== model(0, 0, 3, 5, 0)) begin
      errors++; $display("FAIL rst_high_pre got=%b exp=%b", obs, model(0, 0, 3, 5, 0));
    end
    step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      checks++;
      if (obs !== idle_vec()) begin
        errors++; $display("FAIL rst_high t=%0d got=%b exp=%b", t, obs, idle_vec());
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1, 2, 4, 3);
    launch();
    for (int t = 0; t <= 13; t++) begin
      if (t == 2) begin
        set_cfg(0, 0, 0, 0); start = 1'b1;   // start while busy, even illegal: ignored
      end else if (t == 13) begin
        set_cfg(0, 1, 3, 1); start = 1'b1;   // restart in the done cycle
      end else begin
        start = 1'b0;
      end
      checks++;
      if (obs !== model(t, 1, 2, 4, 3)) begin
        errors++; $display("FAIL b2b_first t=%0d got=%b exp=%b", t, obs, model(t, 1, 2, 4, 3));
      end
      step();
    end
    start = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      checks++;
      if (obs !== model(t, 0, 1, 3, 1)) begin
        errors++; $display("FAIL b2b_second t=%0d got=%b exp=%b", t, obs, model(t, 0, 1, 3, 1));
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 40; b++) begin
      int d, w, p, n, gap, end_t, stop_at;
      d = $urandom_range(0, 5);
      w = $urandom_range(1, 6);
      p = w + $urandom_range(1, 6);
      n = $urandom_range(0, 4);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        checks++;
        if (obs !== idle_vec()) begin
          errors++; $display("FAIL rand_gap b=%0d got=%b exp=%b", b, obs, idle_vec());
        end
        step();
      end
      set_cfg(d, w, p, n);
      launch();
      end_t   = d + n * p;
      stop_at = (n == 0) ? $urandom_range(1, 40) : end_t;
      for (int t = 0; t <= stop_at; t++) begin
        start = (t < end_t || n == 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
        if (n == 0 && t == stop_at) stop = 1'b1;
        checks++;
        if (obs !== model(t, d, w, p, n) || outb !== ~out) begin
          errors++;
          $display("FAIL rand b=%0d D=%0d W=%0d P=%0d N=%0d t=%0d got=%b exp=%b",
                   b, d, w, p, n, t, obs, model(t, d, w, p, n));
        end
        step();
      end
      start = 1'b0; stop = 1'b0;
      checks++;
      if (obs !== idle_vec()) begin
        errors++; $display("FAIL rand_end b=%0d got=%b exp=%b", b, obs, idle_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_min_config();
    test_illegal();
    test_abort();
    test_priority();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
